file_addr_seq: RTL

Runtime-programmable file-to-memory address sequencer for the MNIST accelerator datapath. Holds a table of file-index ranges and their feature-memory regions, accepts a file index over a valid/ready request, and streams every word address of the matching region with backpressure. It replaces the fixed combinational file decode used by the conv/maxpool/matrix stages, so layer layouts can change without RTL edits.

---
 rtl/file_addr_pkg.sv | 23 ++
 rtl/file_region_match.sv | 33 +++
 rtl/file_addr_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/file_addr_pkg.sv
// file_addr_pkg: shared types and default widths for the file address sequencer.
// Region table entry layout and sequencer state encoding.
package file_addr_pkg;

  localparam int DEF_FILE_W      = 16;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_NUM_REGIONS = 16;

  typedef struct packed {
    logic                  valid;
    logic [DEF_FILE_W-1:0] file_lo;
    logic [DEF_FILE_W-1:0] file_hi;
    logic [DEF_ADDR_W-1:0] mem_start;
    logic [DEF_ADDR_W-1:0] mem_end;
  } region_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/file_region_match.sv
// file_region_match: combinational priority matcher over the region table.
// Lowest-index valid entry whose file range covers the file wins.
module file_region_match
  import file_addr_pkg::*;
#(
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
  input  region_entry_t         regions [NUM_REGIONS],
  input  logic [DEF_FILE_W-1:0] file,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx,
  output region_entry_t         entry
);

  // scan high to low so the lowest matching index is the last assignment
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    entry = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (regions[i].valid &&
          regions[i].file_lo <= file &&
          file <= regions[i].file_hi &&
          regions[i].mem_start <= regions[i].mem_end) begin
        hit   = 1'b1;
        idx   = IDX_W'(i);
        entry = regions[i];
      end
    end
  end

endmodule

// File: rtl/file_addr_seq.sv
// file_addr_seq: programmable file-index to feature-memory address streamer.
// Option FILE_ADDR_SEQ_OFFSET_EN gives each file in a range its own slot.
module file_addr_seq
  import file_addr_pkg::*;
#(
  parameter int FILE_W      = DEF_FILE_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_REGIONS = DEF_NUM_REGIONS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
  input  logic [FILE_W-1:0]              cfg_file_lo,
  input  logic [FILE_W-1:0]              cfg_file_hi,
  input  logic [ADDR_W-1:0]              cfg_mem_start,
  input  logic [ADDR_W-1:0]              cfg_mem_end,
  input  logic                           cfg_valid,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [FILE_W-1:0]              req_file,
  input  logic                           abort,
  output logic                           addr_valid,
  input  logic                           addr_ready,
  output logic [ADDR_W-1:0]              addr,
  output logic                           addr_last,
  output logic [ADDR_W-1:0]              file_size,
  output logic [ADDR_W-1:0]              memory_start,
  output logic [ADDR_W-1:0]              memory_end,
  output logic                           miss,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REGIONS);

  state_t             state, state_n;
  region_entry_t      regions [NUM_REGIONS];
  logic [FILE_W-1:0]  file_q;
  logic               hit;
  logic [IDX_W-1:0]   m_idx;
  region_entry_t      m_entry;
  logic [ADDR_W-1:0]  span, base, last_a;
  logic [ADDR_W-1:0]  cnt_n, start_n, end_n, size_n;
  logic               load;
  logic               unused;

  file_region_match #(
    .NUM_REGIONS(NUM_REGIONS)
  ) u_match (
    .regions(regions),
    .file   (file_q),
    .hit    (hit),
    .idx    (m_idx),
    .entry  (m_entry)
  );

  assign unused = ^{m_idx, m_entry.valid, m_entry.file_hi, m_entry.file_lo};

  assign req_ready = (state == ST_IDLE);
  assign load      = (state == ST_LOOKUP) && hit && !abort;

  // region geometry of the matched entry; size wraps for a full-range region
  always_comb begin
    span = m_entry.mem_end - m_entry.mem_start + ADDR_W'(1);
`ifdef FILE_ADDR_SEQ_OFFSET_EN
    base = m_entry.mem_start + ADDR_W'(file_q - m_entry.file_lo) * span;
`else
    base = m_entry.mem_start;
`endif
    last_a = base + span - ADDR_W'(1);
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (req_valid) state_n = ST_LOOKUP;
      ST_LOOKUP: state_n = load ? ST_STREAM : ST_IDLE;
      ST_STREAM: if (abort || (addr_ready && addr_last)) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // next counter and latched request info
  always_comb begin
    cnt_n   = addr;
    start_n = memory_start;
    end_n   = memory_end;
    size_n  = file_size;
    if (load) begin
      cnt_n   = base;
      start_n = base;
      end_n   = last_a;
      size_n  = span;
    end else if (state == ST_STREAM && addr_ready) begin
      cnt_n = addr + ADDR_W'(1);
    end
  end

  // state, stream and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      file_q       <= '0;
      addr         <= '0;
      addr_valid   <= 1'b0;
      addr_last    <= 1'b0;
      file_size    <= '0;
      memory_start <= '0;
      memory_end   <= '0;
      miss         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      addr         <= cnt_n;
      memory_start <= start_n;
      memory_end   <= end_n;
      file_size    <= size_n;
      addr_valid   <= (state_n == ST_STREAM);
      addr_last    <= (state_n == ST_STREAM) && (cnt_n == end_n);
      busy         <= (state_n != ST_IDLE);
      miss         <= (state == ST_LOOKUP) && !hit && !abort;
      if (state == ST_IDLE && req_valid) file_q <= req_file;
    end
  end

  // region table, writable in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) regions[i] <= '0;
    end else if (cfg_we) begin
      regions[cfg_idx] <= '{valid:     cfg_valid,
                            file_lo:   cfg_file_lo,
                            file_hi:   cfg_file_hi,
                            mem_start: cfg_mem_start,
                            mem_end:   cfg_mem_end};
    end
  end

endmodule
